// File: rtl/cpu_run_monitor_if.sv
// Dump stream port: one data-RAM word plus its address, moved on valid && ready.
interface cpu_run_monitor_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
);
  logic              dump_valid;
  logic              dump_ready;
  logic [DATA_W-1:0] dump_data;
  logic [ADDR_W-1:0] dump_addr;

  modport master (
    output dump_valid,
    output dump_data,
    output dump_addr,
    input  dump_ready
  );

  modport slave (
    input  dump_valid,
    input  dump_data,
    input  dump_addr,
    output dump_ready
  );
endinterface

// File: rtl/cpu_run_monitor.sv
// Run control for the CPU: detects the halt sentinel, drains the pipeline, freezes
// the core, then streams the data RAM out while reporting cycle count and status.
module cpu_run_monitor #(
  parameter int                 INSTR_W      = 32,
  parameter logic [INSTR_W-1:0] HALT_WORD    = 32'hFFFF_FFFF,
  parameter int                 DRAIN_CYCLES = 10,
  parameter int                 DUMP_DEPTH   = 512,
  parameter int                 ADDR_W       = 9,
  parameter int                 DATA_W       = 32,
  parameter int                 CYCLE_W      = 32,
  parameter int                 CYCLE_OFFSET = 4,
  parameter int                 MAX_CYCLES   = 100000
) (
  input  logic                clk,
  input  logic                RESET,
  input  logic                start,
  input  logic [INSTR_W-1:0]  instr_d,
  output logic                cpu_stall,
  output logic                dbg_rd_en,
  output logic [ADDR_W-1:0]   dbg_addr,
  input  logic [DATA_W-1:0]   dbg_rd_data,
  cpu_run_monitor_if.master   dump,
  output logic [CYCLE_W-1:0]  cycle_count,
  output logic                halted,
  output logic                timeout,
  output logic                done
);

  // The run counter is kept at least 32 bits wide so the cycle limit can be
  // compared even when the reported count is narrow and already saturated.
  localparam int RUN_W = (CYCLE_W > 32) ? CYCLE_W : 32;
  localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [DRN_W-1:0]  DRAIN_LAST = DRN_W'(DRAIN_CYCLES - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST   = ADDR_W'(DUMP_DEPTH - 1);
  localparam logic [RUN_W-1:0]  RUN_LIMIT  = RUN_W'(MAX_CYCLES);
  localparam logic [RUN_W:0]    CC_MAX     = (RUN_W+1)'({CYCLE_W{1'b1}});
  localparam logic [RUN_W:0]    CC_OFFSET  = (RUN_W+1)'(CYCLE_OFFSET);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_RDREQ,
    ST_RDWAIT,
    ST_PRESENT,
    ST_DONE
  } state_t;

  state_t              state_reg,       state_next;
  logic [RUN_W-1:0]    run_cnt_reg,     run_cnt_next;
  logic [DRN_W-1:0]    drain_cnt_reg,   drain_cnt_next;
  logic [ADDR_W-1:0]   idx_reg,         idx_next;
  logic [CYCLE_W-1:0]  cycle_count_reg, cycle_count_next;
  logic                halted_reg,      halted_next;
  logic                timeout_reg,     timeout_next;
  logic                done_reg,        done_next;
  logic                stall_reg,       stall_next;
  logic                valid_reg,       valid_next;
  logic [DATA_W-1:0]   data_reg,        data_next;
  logic [ADDR_W-1:0]   addr_reg,        addr_next;

  logic [RUN_W-1:0]    run_cnt_inc;
  logic [RUN_W:0]      cc_sum;
  logic [CYCLE_W-1:0]  cc_sat;
  logic                halt_hit;
  logic                limit_hit;
  logic                accept;

  // Both counters saturate so a very long run can never wrap back into range.
  assign run_cnt_inc = (run_cnt_reg == {RUN_W{1'b1}}) ? run_cnt_reg : run_cnt_reg + 1'b1;
  assign cc_sum      = {1'b0, run_cnt_inc} + CC_OFFSET;
  assign cc_sat      = (cc_sum > CC_MAX) ? {CYCLE_W{1'b1}} : cc_sum[CYCLE_W-1:0];

  // An X/Z on instr_d makes the equality unknown, which never selects the halt path.
  assign halt_hit  = (instr_d == HALT_WORD);
  assign limit_hit = (MAX_CYCLES != 0) && (run_cnt_inc == RUN_LIMIT);
  assign accept    = valid_reg && dump.dump_ready;

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state_reg       <= ST_IDLE;
      run_cnt_reg     <= '0;
      drain_cnt_reg   <= '0;
      idx_reg         <= '0;
      cycle_count_reg <= '0;
      halted_reg      <= 1'b0;
      timeout_reg     <= 1'b0;
      done_reg        <= 1'b0;
      stall_reg       <= 1'b1;
      valid_reg       <= 1'b0;
      data_reg        <= '0;
      addr_reg        <= '0;
    end else begin
      state_reg       <= state_next;
      run_cnt_reg     <= run_cnt_next;
      drain_cnt_reg   <= drain_cnt_next;
      idx_reg         <= idx_next;
      cycle_count_reg <= cycle_count_next;
      halted_reg      <= halted_next;
      timeout_reg     <= timeout_next;
      done_reg        <= done_next;
      stall_reg       <= stall_next;
      valid_reg       <= valid_next;
      data_reg        <= data_next;
      addr_reg        <= addr_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    run_cnt_next     = run_cnt_reg;
    drain_cnt_next   = drain_cnt_reg;
    idx_next         = idx_reg;
    cycle_count_next = cycle_count_reg;
    halted_next      = halted_reg;
    timeout_next     = timeout_reg;
    done_next        = done_reg;
    stall_next       = stall_reg;
    valid_next       = valid_reg;
    data_next        = data_reg;
    addr_next        = addr_reg;

    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_next       = ST_RUN;
          run_cnt_next     = '0;
          cycle_count_next = '0;
          halted_next      = 1'b0;
          timeout_next     = 1'b0;
          done_next        = 1'b0;
          stall_next       = 1'b0;
        end
      end

      ST_RUN: begin
        run_cnt_next     = run_cnt_inc;
        cycle_count_next = cc_sat;
        if (halt_hit) begin
          halted_next    = 1'b1;
          drain_cnt_next = '0;
          state_next     = ST_DRAIN;
        end else if (limit_hit) begin
          timeout_next   = 1'b1;
          drain_cnt_next = '0;
          state_next     = ST_DRAIN;
        end
      end

      // Core keeps running so in-flight instructions retire before the freeze.
      ST_DRAIN: begin
        if (drain_cnt_reg == DRAIN_LAST) begin
          stall_next     = 1'b1;
          drain_cnt_next = '0;
          idx_next       = '0;
          state_next     = ST_RDREQ;
        end else begin
          drain_cnt_next = drain_cnt_reg + 1'b1;
        end
      end

      ST_RDREQ: begin
        state_next = ST_RDWAIT;
      end

      ST_RDWAIT: begin
        data_next  = dbg_rd_data;
        addr_next  = idx_reg;
        valid_next = 1'b1;
        state_next = ST_PRESENT;
      end

      ST_PRESENT: begin
        if (accept) begin
          valid_next = 1'b0;
          if (idx_reg == IDX_LAST) begin
            done_next  = 1'b1;
            state_next = ST_DONE;
          end else begin
            idx_next   = idx_reg + 1'b1;
            state_next = ST_RDREQ;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign cpu_stall       = stall_reg;
  assign dbg_rd_en       = (state_reg == ST_RDREQ);
  assign dbg_addr        = idx_reg;
  assign dump.dump_valid = valid_reg;
  assign dump.dump_data  = data_reg;
  assign dump.dump_addr  = addr_reg;
  assign cycle_count     = cycle_count_reg;
  assign halted          = halted_reg;
  assign timeout         = timeout_reg;
  assign done            = done_reg;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Directed bench for cpu_run_monitor: two instances (default build and a narrow
// counter / short limit build) driven from one table of run scenarios.
module tb_cpu_run_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [2];
  logic        start [2];
  logic [31:0] instr [2];
  logic        ready [2];

  int checks = 0;
  int errors = 0;

  // Instance A: default parameters
  logic        stall_a, rden_a, halted_a, timeout_a, done_a;
  logic [8:0]  daddr_a;
  logic [31:0] rdata_a = '0;
  logic [31:0] cc_a;
  int          rdcnt_a = 0;

  cpu_run_monitor_if #(.DATA_W(32), .ADDR_W(9)) dif_a ();
  assign dif_a.dump_ready = ready[0];

  cpu_run_monitor dut_a (
    .clk         (clk),
    .RESET       (rst_n[0]),
    .start       (start[0]),
    .instr_d     (instr[0]),
    .cpu_stall   (stall_a),
    .dbg_rd_en   (rden_a),
    .dbg_addr    (daddr_a),
    .dbg_rd_data (rdata_a),
    .dump        (dif_a),
    .cycle_count (cc_a),
    .halted      (halted_a),
    .timeout     (timeout_a),
    .done        (done_a)
  );

  // Instance B: 4-bit count, 50-cycle limit, short drain and dump
  logic        stall_b, rden_b, halted_b, timeout_b, done_b;
  logic [2:0]  daddr_b;
  logic [31:0] rdata_b = '0;
  logic [3:0]  cc_b;
  int          rdcnt_b = 0;

  cpu_run_monitor_if #(.DATA_W(32), .ADDR_W(3)) dif_b ();
  assign dif_b.dump_ready = ready[1];

  cpu_run_monitor #(
    .DRAIN_CYCLES (3),
    .DUMP_DEPTH   (6),
    .ADDR_W       (3),
    .CYCLE_W      (4),
    .CYCLE_OFFSET (4),
    .MAX_CYCLES   (50)
  ) dut_b (
    .clk         (clk),
    .RESET       (rst_n[1]),
    .start       (start[1]),
    .instr_d     (instr[1]),
    .cpu_stall   (stall_b),
    .dbg_rd_en   (rden_b),
    .dbg_addr    (daddr_b),
    .dbg_rd_data (rdata_b),
    .dump        (dif_b),
    .cycle_count (cc_b),
    .halted      (halted_b),
    .timeout     (timeout_b),
    .done        (done_b)
  );

  // Data RAM models with registered read: word i holds i*3
  always @(posedge clk) begin
    if (rden_a) begin
      rdata_a <= {23'd0, daddr_a} * 32'd3;
      rdcnt_a <= rdcnt_a + 1;
    end
  end

  always @(posedge clk) begin
    if (rden_b) begin
      rdata_b <= {29'd0, daddr_b} * 32'd3;
      rdcnt_b <= rdcnt_b + 1;
    end
  end

  typedef struct {
    logic [31:0] stall, rden, daddr, valid, data, addr, cc, halted, timeout, done;
  } snap_t;

  typedef struct {
    int d;          // instance 0 = A, 1 = B
    int halt_at;    // RUN cycle carrying the sentinel, 0 = never
    int sid;        // pulse start during DRAIN
    int bp_addr;    // dump address held off by dump_ready, -1 = none
    int bp_len;
    int abort_addr; // reset asserted while this address is presented, -1 = none
    int exp_halted;
    int exp_timeout;
    int exp_stop;   // RUN cycle on which the run ends
    int exp_cc;
  } vec_t;

  localparam int NVEC = 10;
  vec_t tbl [NVEC];

  function automatic int depth_of(input int d);
    return (d == 0) ? 512 : 6;
  endfunction

  function automatic int drain_of(input int d);
    return (d == 0) ? 10 : 3;
  endfunction

  function automatic int rdcnt_of(input int d);
    return (d == 0) ? rdcnt_a : rdcnt_b;
  endfunction

  task automatic sample(input int d, output snap_t s);
    if (d == 0) begin
      s.stall = 32'(stall_a);  s.rden = 32'(rden_a);  s.daddr = 32'(daddr_a);
      s.valid = 32'(dif_a.dump_valid); s.data = dif_a.dump_data;
      s.addr  = 32'(dif_a.dump_addr);  s.cc = cc_a;
      s.halted = 32'(halted_a); s.timeout = 32'(timeout_a); s.done = 32'(done_a);
    end else begin
      s.stall = 32'(stall_b);  s.rden = 32'(rden_b);  s.daddr = 32'(daddr_b);
      s.valid = 32'(dif_b.dump_valid); s.data = dif_b.dump_data;
      s.addr  = 32'(dif_b.dump_addr);  s.cc = 32'(cc_b);
      s.halted = 32'(halted_b); s.timeout = 32'(timeout_b); s.done = 32'(done_b);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_reset(input int d, input string tag);
    snap_t s;
    sample(d, s);
    chk({tag, " stall"},   s.stall,   32'd1);
    chk({tag, " rd_en"},   s.rden,    32'd0);
    chk({tag, " dbg_addr"},s.daddr,   32'd0);
    chk({tag, " valid"},   s.valid,   32'd0);
    chk({tag, " data"},    s.data,    32'd0);
    chk({tag, " addr"},    s.addr,    32'd0);
    chk({tag, " cc"},      s.cc,      32'd0);
    chk({tag, " halted"},  s.halted,  32'd0);
    chk({tag, " timeout"}, s.timeout, 32'd0);
    chk({tag, " done"},    s.done,    32'd0);
    $display("dut%0d %s: reset values checked", d, tag);
  endtask

  task automatic run_vec(input vec_t v, input int n);
    snap_t s;
    int    d;
    int    stop;
    int    drn;
    int    w;
    int    base;
    string t;
    d = v.d;
    t = $sformatf("v%0d", n);

    @(negedge clk); start[d] = 1'b1; instr[d] = '0;
    @(negedge clk); start[d] = 1'b0;
    sample(d, s);
    chk({t, " run stall"},   s.stall,   32'd0);
    chk({t, " run cc"},      s.cc,      32'd0);
    chk({t, " run halted"},  s.halted,  32'd0);
    chk({t, " run timeout"}, s.timeout, 32'd0);
    chk({t, " run done"},    s.done,    32'd0);

    stop = 0;
    for (int c = 1; c <= 200; c++) begin
      instr[d] = (c == v.halt_at) ? 32'hFFFF_FFFF : 32'(c);
      @(negedge clk);
      sample(d, s);
      if (s.halted != 0 || s.timeout != 0) begin
        stop = c;
        break;
      end
    end
    instr[d] = '0;
    chk({t, " stop cycle"}, 32'(stop),   32'(v.exp_stop));
    chk({t, " halted"},     s.halted,    32'(v.exp_halted));
    chk({t, " timeout"},    s.timeout,   32'(v.exp_timeout));
    chk({t, " cc"},         s.cc,        32'(v.exp_cc));
    chk({t, " stall@det"},  s.stall,     32'd0);
    if (stop == 0) return;

    drn = 0;
    for (int k = 1; k <= 50; k++) begin
      start[d] = (v.sid != 0 && k == 2);
      @(negedge clk);
      sample(d, s);
      if (s.stall != 0) begin
        drn = k;
        break;
      end
    end
    start[d] = 1'b0;
    chk({t, " drain len"},   32'(drn), 32'(drain_of(d)));
    chk({t, " drain cc"},    s.cc,     32'(v.exp_cc));
    chk({t, " drain halted"},s.halted, 32'(v.exp_halted));
    if (drn == 0) return;

    base = rdcnt_of(d);
    for (int i = 0; i < depth_of(d); i++) begin
      w = 0;
      while (s.valid == 0 && w < 8) begin
        @(negedge clk);
        sample(d, s);
        w++;
      end
      if (s.valid == 0) begin
        chk($sformatf("%s valid wait @%0d", t, i), s.valid, 32'd1);
        return;
      end
      chk($sformatf("%s addr @%0d", t, i), s.addr, 32'(i));
      chk($sformatf("%s data @%0d", t, i), s.data, 32'(i * 3));

      if (i == v.abort_addr) begin
        rst_n[d] = 1'b0;
        #1;
        chk_reset(d, {t, " abort"});
        @(negedge clk);
        rst_n[d] = 1'b1;
        return;
      end

      if (i == v.bp_addr) begin
        ready[d] = 1'b0;
        for (int j = 0; j < v.bp_len; j++) begin
          @(negedge clk);
          sample(d, s);
          chk($sformatf("%s bp valid %0d", t, j), s.valid, 32'd1);
          chk($sformatf("%s bp addr %0d", t, j),  s.addr,  32'(i));
          chk($sformatf("%s bp data %0d", t, j),  s.data,  32'(i * 3));
          chk($sformatf("%s bp rd_en %0d", t, j), 32'(rdcnt_of(d) - base), 32'(i + 1));
        end
        ready[d] = 1'b1;
      end

      @(negedge clk);
      sample(d, s);
      chk($sformatf("%s post-accept valid @%0d", t, i), s.valid, 32'd0);
      chk($sformatf("%s done @%0d", t, i), s.done, 32'(i == depth_of(d) - 1));
    end
    chk({t, " rd_en pulses"}, 32'(rdcnt_of(d) - base), 32'(depth_of(d)));

    repeat (3) @(negedge clk);
    sample(d, s);
    chk({t, " hold done"},   s.done,   32'd1);
    chk({t, " hold stall"},  s.stall,  32'd1);
    chk({t, " hold cc"},     s.cc,     32'(v.exp_cc));
    chk({t, " hold halted"}, s.halted, 32'(v.exp_halted));
  endtask

  initial begin
    //            d halt sid bp len abort h  t  stop cc
    tbl[0] = '{0, 20, 0,  7, 5,  -1,  1, 0, 20,  24};
    tbl[1] = '{0, 30, 0, -1, 0, 100,  1, 0, 30,  34};
    tbl[2] = '{0,  7, 0, -1, 0,  -1,  1, 0,  7,  11};
    tbl[3] = '{1, 20, 1, -1, 0,  -1,  1, 0, 20,  15};
    tbl[4] = '{1,  0, 0, -1, 0,  -1,  0, 1, 50,  15};
    tbl[5] = '{1, 50, 0, -1, 0,  -1,  1, 0, 50,  15};
    tbl[6] = '{1,  5, 0, -1, 0,  -1,  1, 0,  5,   9};
    tbl[7] = '{1, 11, 0, -1, 0,  -1,  1, 0, 11,  15};
    tbl[8] = '{1, 10, 0, -1, 0,  -1,  1, 0, 10,  14};
    tbl[9] = '{1,  1, 0,  5, 3,  -1,  1, 0,  1,   5};

    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b1;
      start[d] = 1'b0;
      instr[d] = '0;
      ready[d] = 1'b1;
    end
    #2;
    rst_n[0] = 1'b0;
    rst_n[1] = 1'b0;
    #1;
    chk_reset(0, "por");
    chk_reset(1, "por");
    repeat (2) @(negedge clk);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset(0, "idle");

    for (int n = 0; n < NVEC; n++) begin
      run_vec(tbl[n], n);
      $display("v%0d dut%0d halt_at=%0d done, errors so far %0d", n, tbl[n].d, tbl[n].halt_at, errors);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_run_monitor.md
Name: cpu_run_monitor

Overview:
Synthesizable run-control and result-dump block for the pipelined CPU; it replaces bench-only halt detection and RAM dumping.
- Watches the decode-stage instruction for a halt sentinel, then lets the pipeline drain for a fixed number of cycles.
- Freezes the core, then streams data-RAM words out over a valid/ready port through a debug read port.
- Counts executed cycles and adds a configurable pipeline-fill offset; a cycle-limit timeout catches runaway programs.

Parameters:
INSTR_W, 32, decode instruction width
HALT_WORD, 32'hFFFF_FFFF, sentinel that ends a run
DRAIN_CYCLES, 10, cycles allowed after the halt is seen before the core freezes (>=1)
DUMP_DEPTH, 512, number of data-RAM words streamed out (>=1)
ADDR_W, 9, debug address width; must satisfy 2^ADDR_W >= DUMP_DEPTH
DATA_W, 32, data-RAM word width
CYCLE_W, 32, cycle counter width
CYCLE_OFFSET, 4, constant added to the reported cycle count (pipeline fill)
MAX_CYCLES, 100000, run-cycle limit before timeout; 0 disables the limit

Ports:
clk  in  1  system clock, rising edge
RESET  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse that begins a run; honoured only in IDLE or DONE
instr_d  in  INSTR_W  decode-stage instruction from the core
cpu_stall  out  1  freezes the core (PC and all pipeline registers)
dbg_rd_en  out  1  debug read strobe to data RAM
dbg_addr  out  ADDR_W  debug read address
dbg_rd_data  in  DATA_W  read data; valid exactly 1 cycle after dbg_rd_en
dump_valid  out  1  dump word is available
dump_ready  in  1  consumer accepts the dump word
dump_data  out  DATA_W  dump word
dump_addr  out  ADDR_W  address of dump_data
cycle_count  out  CYCLE_W  reported cycles
halted  out  1  sentinel was detected in the current run
timeout  out  1  cycle limit was hit in the current run
done  out  1  dump complete; held until the next start

Behaviour:
- Reset values (asynchronous, RESET=0):
  - state=IDLE.
  - cpu_stall=1, dbg_rd_en=0, dbg_addr=0, dump_valid=0, dump_data=0, dump_addr=0.
  - cycle_count=0, halted=0, timeout=0, done=0.
- Deassertion of RESET is synchronised by the parent; this block assumes a clean release.
- States: IDLE, RUN, DRAIN, RDREQ, RDWAIT, PRESENT, DONE.
- IDLE/DONE + start:
  - Go to RUN; clear cycle_count, halted, timeout, done.
  - Set the internal run counter to 0; cpu_stall=0 from the next cycle.
- RUN:
  - Each cycle: run counter +1; cycle_count = run counter + CYCLE_OFFSET, saturating at all-ones.
  - instr_d===HALT_WORD: halted=1, go to DRAIN.
  - Otherwise, if MAX_CYCLES!=0 and the run counter reaches MAX_CYCLES: timeout=1, go to DRAIN.
  - Both conditions in the same cycle: halt wins; timeout stays 0.
  - An X or Z on instr_d never matches.
- DRAIN:
  - Core still runs; cycle_count stops updating.
  - After exactly DRAIN_CYCLES cycles in DRAIN: cpu_stall=1, drain counter cleared, dump index=0, go to RDREQ.
- Dump (cpu_stall stays 1 throughout):
  - RDREQ: dbg_rd_en=1 for 1 cycle, dbg_addr=index; go to RDWAIT.
  - RDWAIT: capture dbg_rd_data into dump_data and index into dump_addr; dump_valid=1; go to PRESENT.
  - PRESENT: dump_data and dump_addr stay stable while valid && !ready.
  - On valid && ready:
    - If index==DUMP_DEPTH-1: dump_valid=0, done=1, go to DONE.
    - Else: index+1, dump_valid=0, go to RDREQ.
  - Throughput is at best 1 word per 3 cycles; bubbles are acceptable.
- DONE: all flags and cycle_count hold; cpu_stall=1; start restarts the run.
- start in RUN, DRAIN, or any dump state is ignored.
- Reset mid-dump aborts immediately to reset values; no partial state survives.
- cycle_count saturation: once all-ones, stays all-ones; no wrap.

Test Plan:
- Defaults, halt word appears in RUN cycle 20 -> halted=1; cycle_count=24; cpu_stall rises exactly 10 cycles after detection; timeout=0.
- Dump with dump_ready tied 1, RAM preloaded with word i = i*3 -> 512 valid beats; dump_addr 0..511 in order; dump_data=i*3; done=1 after the last beat; dbg_rd_en pulses 512 times.
- Backpressure: dump_ready low for 5 cycles at addr 7 -> dump_valid, dump_data and dump_addr stable all 5 cycles; no dbg_rd_en issued; addr 8 follows the accept.
- MAX_CYCLES=50, no halt word -> timeout=1 and halted=0; DRAIN entered after run count 50; dump still completes. Halt and limit in the same cycle -> halted=1, timeout=0.
- Reset low in mid-PRESENT at addr 100 -> all outputs reach reset values asynchronously; a new start yields a fresh run with cycle_count restarted.
- CYCLE_W=4, CYCLE_OFFSET=4, halt at cycle 20 -> cycle_count saturates at 15 and holds; start pulsed during DRAIN is ignored.
